obstacle_spawner: RTL
=====================

OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter MIN_GAP, default 32: minimum spawn gap in frame ticks.
REQ-002 SHALL have parameter GAP_BITS, default 6: number of random bits added to MIN_GAP; MIN_GAP + 2^GAP_BITS - 1 <= 255.
REQ-003 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port run_i, input, 1: game running; low forces IDLE.
REQ-006 SHALL have port tick_i, input, 1: one-cycle frame-tick strobe.
REQ-007 SHALL have port rand_i, input, 16: current value from the 16-bit LFSR.
REQ-008 SHALL have port rand_next_o, output, 1: one-cycle advance strobe, wired to the LFSR next input.
REQ-009 SHALL have port spawn_valid_o, output, 1: obstacle request valid.
REQ-010 SHALL have port spawn_ready_i, input, 1: obstacle slot free, request accepted.
REQ-011 SHALL have port spawn_type_o, output, 2: obstacle type of the pending request.
REQ-012 SHALL have port spawn_count_o, output, 8: accepted spawns since reset.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, WAIT and SPAWN, one register each for state, gap_q[7:0], type_q[1:0] and count_q[7:0].
REQ-014 IDLE: SHALL go to LOAD on the next edge when run_i=1; otherwise stay in IDLE.
REQ-015 LOAD (exactly one cycle): SHALL set gap_q <= MIN_GAP + rand_i[GAP_BITS-1:0] and type_q <= rand_i[GAP_BITS+1:GAP_BITS], assert rand_next_o=1, then go to WAIT.
REQ-016 rand_next_o SHALL be high only in the LOAD cycle: exactly one pulse per scheduled obstacle.
REQ-017 WAIT: on tick_i=1 with gap_q==0, SHALL go to SPAWN; on tick_i=1 with gap_q!=0, SHALL decrement gap_q; without tick_i, gap_q SHALL hold.
REQ-018 A loaded gap G SHALL therefore give SPAWN after exactly G+1 ticks in WAIT; a tick in the LOAD cycle SHALL be ignored.
REQ-019 SPAWN: spawn_valid_o SHALL be 1, with spawn_type_o = type_q held stable until acceptance.
REQ-020 Acceptance SHALL be spawn_valid_o && spawn_ready_i on a clock edge; on acceptance: count_q SHALL increment and the FSM SHALL go to LOAD.
REQ-021 spawn_valid_o SHALL be 0 in IDLE, LOAD and WAIT; spawn_type_o SHALL be type_q in all states.
REQ-022 spawn_ready_i held low in SPAWN SHALL stall indefinitely; tick_i SHALL be ignored in SPAWN.
REQ-023 count_q SHALL wrap 255 -> 0 without saturation; spawn_count_o = count_q.
REQ-024 run_i=0 in any state SHALL force IDLE on the next edge, with priority over tick_i and acceptance.
REQ-025 In an edge where run_i=0 and SPAWN is accepted, count_q SHALL NOT increment: the pending request is dropped.
REQ-026 Leaving for IDLE SHALL retain gap_q, type_q and count_q; re-entry SHALL always pass through LOAD.
REQ-027 Output timing: all outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.

Reset
REQ-028 rst_i=1 SHALL immediately, without a clock, set state=IDLE, gap_q=0, type_q=0 and count_q=0.
REQ-029 During reset: rand_next_o=0, spawn_valid_o=0, spawn_type_o=0 and spawn_count_o=0.
REQ-030 Reset asserted in any state, including SPAWN mid-handshake, SHALL abort that state; after release the FSM SHALL need run_i=1 to leave IDLE.

Verification
REQ-031 Basic spawn: defaults, run_i=1, rand_i=16'h0045 at LOAD -> one rand_next_o pulse, gap_q=37, spawn_valid_o rises after the 38th tick, spawn_type_o=2'b01.
REQ-032 Back-pressure: in SPAWN, spawn_ready_i=0 for 10 cycles with ticks -> spawn_valid_o stays 1, type stable, count unchanged; ready=1 -> count +1, LOAD next cycle.
REQ-033 Run drop: run_i=0 in WAIT with gap_q=12 -> IDLE next cycle, no spawn_valid_o; run_i=1 -> LOAD and a fresh rand_next_o pulse.
REQ-034 Simultaneous events: run_i=0 and spawn_ready_i=1 in the same SPAWN cycle -> IDLE, count unchanged.
REQ-035 Counter wrap: 256 accepted spawns with ready tied high -> spawn_count_o returns to 0; exactly 256 rand_next_o pulses.
REQ-036 Async reset: rst_i pulsed mid-cycle in SPAWN with count=5 -> spawn_valid_o=0 and spawn_count_o=0 before the next clock edge.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Obstacle spawn scheduler: draws a random gap and type from the LFSR, counts
// frame ticks down, then holds a valid/ready spawn request until it is accepted.
module obstacle_spawner #(
  parameter int MIN_GAP  = 32,
  parameter int GAP_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        tick_i,
  input  logic [15:0] rand_i,
  output logic        rand_next_o,
  output logic        spawn_valid_o,
  input  logic        spawn_ready_i,
  output logic [1:0]  spawn_type_o,
  output logic [7:0]  spawn_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_SPAWN} state_t;

  localparam logic [7:0] MIN_GAP8 = 8'(MIN_GAP);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_gap;
  logic [1:0]  r_type;
  logic [7:0]  r_count;
  logic [7:0]  w_gap_load;
  logic [1:0]  w_type_load;
  logic        w_accept;

  assign w_gap_load  = MIN_GAP8 + 8'(rand_i[GAP_BITS-1:0]);
  assign w_type_load = rand_i[GAP_BITS+1:GAP_BITS];
  // A dropped run request wins over a simultaneous handshake.
  assign w_accept    = (r_state == S_SPAWN) && spawn_ready_i && run_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run_i) w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  if (tick_i && (r_gap == 8'd0)) w_next = S_SPAWN;
      S_SPAWN: if (spawn_ready_i) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
    if (!run_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gap   <= 8'd0;
      r_type  <= 2'd0;
      r_count <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_gap  <= w_gap_load;
        r_type <= w_type_load;
      end else if ((r_state == S_WAIT) && run_i && tick_i && (r_gap != 8'd0)) begin
        r_gap <= r_gap - 8'd1;
      end
      if (w_accept) r_count <= r_count + 8'd1;
    end
  end

  // Outputs depend on registered state only.
  assign rand_next_o   = (r_state == S_LOAD);
  assign spawn_valid_o = (r_state == S_SPAWN);
  assign spawn_type_o  = r_type;
  assign spawn_count_o = r_count;

endmodule
